// File: rtl/seg7_pkg.sv
// Shared display codes, limits, FSM states and BCD helper for the
// seven-segment number formatter.
package seg7_pkg;

    localparam logic [3:0]  SEG_DASH      = 4'hA;
    localparam logic [3:0]  SEG_BLANK     = 4'hB;
    localparam logic [15:0] SEG_ALL_DASH  = 16'hAAAA;
    localparam logic [15:0] SEG_ALL_BLANK = 16'hBBBB;

    localparam int unsigned MAX_POS     = 9999;
    localparam int unsigned MAX_NEG_MAG = 999;

    localparam int unsigned BIN_W = 14;
    localparam int unsigned BCD_W = 16;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        FMT
    } state_e;

    // Double-dabble correction: add 3 to every nibble that is 5 or more.
    function automatic logic [15:0] add3_bcd4(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_num_fmt.sv
// Signed sample to packed seven-segment nibbles: sequential double-dabble
// followed by sign, leading-zero blanking and overflow formatting.
module seg7_num_fmt
    import seg7_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [15:0]       x_o,
    output logic              done_o
);

    localparam int unsigned   EXT_W    = 17;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W - 1);

    state_e              state_q;
    logic                neg_q;
    logic                ovf_q;
    logic [BIN_W-1:0]    bin_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                accept_c;
    logic                neg_in_c;
    logic                ovf_in_c;
    logic [DATA_W-1:0]   mag_c;
    logic [EXT_W-1:0]    mag_ext_c;
    logic [BCD_W-1:0]    corr_c;
    logic [BCD_W-1:0]    bcd_d;
    logic [BIN_W-1:0]    bin_d;
    logic [15:0]         fmt_c;

    assign ready_o  = (state_q == IDLE);
    assign accept_c = valid_i & ready_o;

    // Magnitude in DATA_W unsigned bits keeps the most negative value exact.
    assign neg_in_c  = data_i[DATA_W-1];
    assign mag_c     = neg_in_c ? DATA_W'(-data_i) : data_i;
    assign mag_ext_c = EXT_W'(mag_c);
    assign ovf_in_c  = neg_in_c ? (mag_ext_c > EXT_W'(MAX_NEG_MAG))
                                : (mag_ext_c > EXT_W'(MAX_POS));

    // One double-dabble step: correct, then shift {bcd, bin} left by one.
    assign corr_c = add3_bcd4(bcd_q);
    assign bcd_d  = BCD_W'({corr_c, bin_q[BIN_W-1]});
    assign bin_d  = {bin_q[BIN_W-2:0], 1'b0};

    always_comb begin
        logic [3:0] d3, d2, d1, d0;
        logic       lz3, lz2, lz1;
        fmt_c = SEG_ALL_DASH;
        d3    = bcd_q[15:12];
        d2    = bcd_q[11:8];
        d1    = bcd_q[7:4];
        d0    = bcd_q[3:0];
        lz3   = 1'b0;
        lz2   = 1'b0;
        lz1   = 1'b0;
        if (!ovf_q) begin
            if (neg_q) begin
                lz2   = (d2 == 4'd0);
                lz1   = lz2 && (d1 == 4'd0);
                fmt_c = {SEG_DASH,
                         lz2 ? SEG_BLANK : d2,
                         lz1 ? SEG_BLANK : d1,
                         d0};
            end else begin
                lz3   = (d3 == 4'd0);
                lz2   = lz3 && (d2 == 4'd0);
                lz1   = lz2 && (d1 == 4'd0);
                fmt_c = {lz3 ? SEG_BLANK : d3,
                         lz2 ? SEG_BLANK : d2,
                         lz1 ? SEG_BLANK : d1,
                         d0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            x_o     <= SEG_ALL_BLANK;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        neg_q   <= neg_in_c;
                        ovf_q   <= ovf_in_c;
                        bin_q   <= mag_ext_c[BIN_W-1:0];
                        bcd_q   <= '0;
                        cnt_q   <= CNT_INIT;
                        state_q <= ovf_in_c ? FMT : CONV;
                    end
                end
                CONV: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    if (cnt_q == '0) begin
                        state_q <= FMT;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                FMT: begin
                    x_o     <= fmt_c;
                    done_o  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
